// File: rtl/przesuniecie_prawo_seq.sv
// ============================================================================
// Module      : przesuniecie_prawo_seq
// Description : Iterative sign-magnitude right shifter, one bit per clock,
//               with start/busy/valid handshake and error/overflow/inexact.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module przesuniecie_prawo_seq #(
   parameter  int BITS  = 32,
   localparam int CNT_W = $clog2(BITS) + 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic [BITS-1:0] i_arg_A,
   input  logic [BITS-1:0] i_arg_B,
   output logic            o_busy,
   output logic            o_valid,
   output logic [BITS-1:0] o_result,
   output logic            o_error,
   output logic            o_overflow,
   output logic            o_inexact
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [BITS-1:0]  c_BITS_VAL = BITS'(BITS);
   localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(BITS - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sign;
   logic [BITS-2:0]  r_mag;
   logic             r_sticky;

   logic             w_neg_b;
   logic             w_ovf_b;
   logic             w_zero_b;
   logic [CNT_W-1:0] w_cnt_init;
   logic [BITS-2:0]  w_mag_next;
   logic             w_sticky_next;

   assign w_neg_b       = i_arg_B[BITS-1];
   assign w_ovf_b       = !w_neg_b && (i_arg_B > c_BITS_VAL);
   assign w_zero_b      = (i_arg_B == '0);
   // A shift by BITS clears the magnitude exactly like a shift by BITS-1.
   assign w_cnt_init    = (i_arg_B == c_BITS_VAL) ? c_CNT_MAX : i_arg_B[CNT_W-1:0];
   assign w_mag_next    = r_mag >> 1;
   assign w_sticky_next = r_sticky | r_mag[0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_sign     <= 1'b0;
         r_mag      <= '0;
         r_sticky   <= 1'b0;
         o_busy     <= 1'b0;
         o_valid    <= 1'b0;
         o_result   <= '0;
         o_error    <= 1'b0;
         o_overflow <= 1'b0;
         o_inexact  <= 1'b0;
      end else begin
         // Handshake outputs trail the state by one cycle.
         o_busy  <= (r_state != S_IDLE);
         o_valid <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_sign     <= i_arg_A[BITS-1];
                  r_mag      <= i_arg_A[BITS-2:0];
                  r_sticky   <= 1'b0;
                  r_cnt      <= '0;
                  o_error    <= 1'b0;
                  o_overflow <= 1'b0;
                  o_inexact  <= 1'b0;
                  if (w_neg_b) begin
                     o_error  <= 1'b1;
                     o_result <= i_arg_A;
                     r_state  <= S_DONE;
                  end else if (w_ovf_b) begin
                     o_overflow <= 1'b1;
                     o_inexact  <= |i_arg_A[BITS-2:0];
                     o_result   <= {i_arg_A[BITS-1], {(BITS-1){1'b0}}};
                     r_mag      <= '0;
                     r_sticky   <= |i_arg_A[BITS-2:0];
                     r_state    <= S_DONE;
                  end else if (w_zero_b) begin
                     o_result <= i_arg_A;
                     r_state  <= S_DONE;
                  end else begin
                     r_cnt   <= w_cnt_init;
                     r_state <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               r_mag    <= w_mag_next;
               r_sticky <= w_sticky_next;
               r_cnt    <= r_cnt - c_CNT_ONE;
               if (r_cnt == c_CNT_ONE) begin
                  o_result  <= {r_sign, w_mag_next};
                  o_inexact <= w_sticky_next;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
